i2c_txn_arbiter: RTL and testbench
==================================

I2C_TXN_ARBITER -- requirements
Module: i2c_txn_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have these parameters:
- N_REQ, default 4, number of requesters (2..8).
- TIMEOUT_CYC, default 65535, watchdog limit in clk cycles; used only under the configuration macro.
REQ-003 The block SHALL have these ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  N_REQ  per-requester transaction request
- req_ready  output  N_REQ  per-requester one-cycle completion pulse
- req_direct  input  N_REQ  per-requester direction bit, forwarded unmodified
- req_addr  input  8*N_REQ  register address; requester i occupies bits [8i+7:8i]
- req_din  input  8*N_REQ  write data; same packing as req_addr
- req_dout  output  8  read data, shared, valid while any req_ready bit is high
- req_err  output  1  timeout flag, valid with req_ready (macro only)
- grant_id  output  3  index of the current or last granted requester
- m_valid  output  1  downstream transaction request
- m_ready  input  1  downstream one-cycle completion pulse
- m_direct  output  1  downstream direction
- m_addr  output  8  downstream address
- m_din  output  8  downstream write data
- m_dout  input  8  downstream read data, valid while m_ready is high

Function
REQ-004 The block SHALL implement a three-state FSM: IDLE, BUSY, RESP.
REQ-005 In IDLE with any req_valid bit high, the block SHALL:
- grant by round-robin, searching upward from last grant + 1 and wrapping modulo N_REQ;
- latch that requester's direct, addr and din;
- load grant_id;
- enter BUSY.
REQ-006 In BUSY, m_valid SHALL be 1 and m_direct/m_addr/m_din SHALL hold the latched values, stable until exit.
REQ-007 In BUSY with m_ready=1, the block SHALL capture m_dout and enter RESP; m_valid SHALL be 0 the following cycle.
REQ-008 In RESP, req_ready[grant_id] SHALL be 1 for exactly one cycle, req_dout SHALL show the captured byte, and the FSM SHALL then enter IDLE.
REQ-009 Fixed latency SHALL be:
- m_valid rises 1 cycle after a grant is taken in IDLE;
- req_ready rises 1 cycle after m_ready;
- consecutive downstream transactions are separated by at least 2 cycles with m_valid=0.
REQ-010 Requesters SHALL hold valid and data fields until req_ready; the block SHALL use only the values latched at grant.
REQ-011 If the granted requester drops req_valid mid-transaction, the transaction SHALL still complete and the req_ready pulse SHALL still be issued.
REQ-012 All req_ready bits other than the granted one SHALL be 0 at all times, and at most one bit SHALL be high in any cycle.
REQ-013 m_ready received in IDLE or RESP SHALL be ignored.
REQ-014 A single requester asserting continuously SHALL be re-granted every transaction.
REQ-015 With all requesters asserting continuously, the grant order SHALL be 0,1,...,N_REQ-1,0,...

Reset
REQ-016 While rst=1, the block SHALL hold:
- FSM in IDLE;
- m_valid=0 and req_ready=0;
- req_dout, m_addr, m_din, m_direct, grant_id and req_err all 0;
- round-robin pointer set so requester 0 has highest priority.
REQ-017 A reset during BUSY SHALL drop m_valid in the following cycle and SHALL NOT issue req_ready; the downstream controller shares rst.

Configuration
REQ-018 With I2C_ARB_TIMEOUT_EN defined, a 16-bit watchdog SHALL behave as follows:
- it clears on entry to BUSY and increments each BUSY cycle;
- on reaching TIMEOUT_CYC-1 without m_ready, the FSM enters RESP with req_err=1 and req_dout=8'hFF, and m_valid drops;
- if m_ready arrives in the expiry cycle, m_ready wins and req_err=0.
REQ-019 Without I2C_ARB_TIMEOUT_EN, no watchdog logic SHALL exist, req_err SHALL be tied to 0, and BUSY SHALL wait indefinitely.

Structure
REQ-020 Package i2c_arb_pkg SHALL hold:
- the FSM state enumeration (2-bit);
- the constant ARB_ERR_DATA = 8'hFF;
- the maximum N_REQ constant (8).
REQ-021 The round-robin selection SHALL be a sub-module, rr_pick: combinational, with inputs request vector and pointer, and outputs one-hot grant and index; all state SHALL stay in i2c_txn_arbiter.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single write: req_valid[2]=1, addr=8'h10, din=8'hA5; m_ready after 5 cycles -> m_addr=8'h10, m_din=8'hA5 for 5 cycles; req_ready[2] pulses 1 cycle after m_ready; grant_id=2.
- Contention: all 4 requesters held valid from reset -> grants 0,1,2,3,0 in order; never two req_ready bits high in one cycle.
- Read return: m_dout=8'h3C with m_ready -> req_dout=8'h3C in the req_ready cycle.
- Requester drops valid mid-transaction -> m_valid held until m_ready; req_ready still pulses.
- Reset in BUSY -> m_valid=0 the next cycle; no req_ready; after release, requester 0 wins a tie with requester 3.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, m_ready never asserted -> req_ready pulses with req_err=1 and req_dout=8'hFF 16 cycles into BUSY; a second run with m_ready exactly at expiry -> req_err=0.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared FSM encoding and constants for the I2C transaction arbiter
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam logic [7:0] ARB_ERR_DATA = 8'hFF;
  localparam int         ARB_MAX_REQ  = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker; searches upward from ptr, wrapping at N_REQ
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [N_REQ-1:0] grant,
  output logic [2:0]       idx
);

  logic       found;
  logic [3:0] cand;

  // Walk candidates in priority order; the inner loop keeps every index constant.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = {1'b0, ptr} + 4'(off);
      if (cand >= 4'(N_REQ)) begin
        cand = cand - 4'(N_REQ);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && (cand == 4'(i)) && req[i]) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          idx      = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin arbiter of N_REQ requesters onto one I2C register port; watchdog under I2C_ARB_TIMEOUT_EN
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ-1:0]     req_direct,
  input  logic [8*N_REQ-1:0]   req_addr,
  input  logic [8*N_REQ-1:0]   req_din,
  output logic [7:0]           req_dout,
  output logic                 req_err,
  output logic [2:0]           grant_id,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_direct,
  output logic [7:0]           m_addr,
  output logic [7:0]           m_din,
  input  logic [7:0]           m_dout
);

  if (N_REQ < 2 || N_REQ > ARB_MAX_REQ || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_bad_param
    $error("i2c_txn_arbiter: parameter out of range");
  end

  arb_state_t       state, state_nxt;
  logic [2:0]       ptr;
  logic [N_REQ-1:0] pick_grant;
  logic [2:0]       pick_idx;
  logic             sel_direct;
  logic [7:0]       sel_addr, sel_din;
  logic             expire;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_direct = 1'b0;
    sel_addr   = '0;
    sel_din    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_direct = sel_direct | req_direct[i];
        sel_addr   = sel_addr | req_addr[8*i +: 8];
        sel_din    = sel_din | req_din[8*i +: 8];
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] wd;
  logic        err_q;

  assign expire  = (wd == WD_LAST);
  assign req_err = err_q;

  // Cleared throughout IDLE so it always starts from zero on entry to BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd    <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == ST_BUSY) begin
        wd <= wd + 16'd1;
      end else begin
        wd <= '0;
      end
      if (state == ST_BUSY && state_nxt == ST_RESP) begin
        err_q <= !m_ready;
      end
    end
  end
`else
  assign expire  = 1'b0;
  assign req_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|req_valid) state_nxt = ST_BUSY;
      ST_BUSY: if (m_ready || expire) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (state == ST_RESP) && (grant_id == 3'(i));
    end
  end

  assign m_valid = (state == ST_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      grant_id <= '0;
      m_direct <= 1'b0;
      m_addr   <= '0;
      m_din    <= '0;
      req_dout <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && |req_valid) begin
        grant_id <= pick_idx;
        m_direct <= sel_direct;
        m_addr   <= sel_addr;
        m_din    <= sel_din;
        ptr      <= (pick_idx == 3'(N_REQ - 1)) ? 3'd0 : pick_idx + 3'd1;
      end
      // A real completion takes precedence over an expiring watchdog.
      if (state == ST_BUSY) begin
        if (m_ready) begin
          req_dout <= m_dout;
        end else if (expire) begin
          req_dout <= ARB_ERR_DATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - directed self-checking bench for i2c_txn_arbiter
module tb_i2c_txn_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_direct;
  logic [8*N-1:0] req_addr;
  logic [8*N-1:0] req_din;
  logic [7:0]     req_dout;
  logic           req_err;
  logic [2:0]     grant_id;
  logic           m_valid;
  logic           m_ready;
  logic           m_direct;
  logic [7:0]     m_addr;
  logic [7:0]     m_din;
  logic [7:0]     m_dout;

  int total = 0;
  int bad   = 0;

  i2c_txn_arbiter #(.N_REQ(N), .TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_direct (req_direct),
    .req_addr   (req_addr),
    .req_din    (req_din),
    .req_dout   (req_dout),
    .req_err    (req_err),
    .grant_id   (grant_id),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_direct   (m_direct),
    .m_addr     (m_addr),
    .m_din      (m_din),
    .m_dout     (m_dout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_direct = '0; req_addr = '0; req_din = '0;
    m_ready = 1'b0; m_dout = '0;
    step(); step();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
    total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL rst_grant_id got=%0d exp=0", grant_id); end
    total++; if ({m_addr, m_din, m_direct, req_dout, req_err} !== 26'd0) begin
      bad++; $display("FAIL rst_regs got addr=%h din=%h dir=%b dout=%h err=%b exp all 0", m_addr, m_din, m_direct, req_dout, req_err);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_write();
    req_valid[2] = 1'b1; req_direct[2] = 1'b0; req_addr[23:16] = 8'h10; req_din[23:16] = 8'hA5;
    step();
    total++; if (grant_id !== 3'd2) begin bad++; $display("FAIL wr_grant got=%0d exp=2", grant_id); end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      total++;
      if (m_valid !== 1'b1 || m_addr !== 8'h10 || m_din !== 8'hA5 || req_ready !== 4'b0000) begin
        bad++; $display("FAIL wr_busy cyc=%0d got v=%b a=%h d=%h rdy=%b exp v=1 a=10 d=a5 rdy=0000", c, m_valid, m_addr, m_din, req_ready);
      end
    end
    m_ready = 1'b1; m_dout = 8'h00;
    step();
    m_ready = 1'b0;
    total++; if (req_ready !== 4'b0100 || m_valid !== 1'b0) begin
      bad++; $display("FAIL wr_resp got rdy=%b v=%b exp rdy=0100 v=0", req_ready, m_valid);
    end
    req_valid = '0;
    step();
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL wr_pulse_len got=%b exp=0000", req_ready); end
  endtask

  task automatic test_read_return();
    req_valid[1] = 1'b1; req_direct[1] = 1'b1; req_addr[15:8] = 8'h22; req_din[15:8] = 8'h00;
    step();
    total++; if (grant_id !== 3'd1 || m_direct !== 1'b1 || m_addr !== 8'h22) begin
      bad++; $display("FAIL rd_grant got id=%0d dir=%b a=%h exp id=1 dir=1 a=22", grant_id, m_direct, m_addr);
    end
    m_ready = 1'b1; m_dout = 8'h3C;
    step();
    m_ready = 1'b0; m_dout = 8'h00;
    total++; if (req_ready !== 4'b0010 || req_dout !== 8'h3C) begin
      bad++; $display("FAIL rd_data got rdy=%b dout=%h exp rdy=0010 dout=3c", req_ready, req_dout);
    end
    req_valid = '0; req_direct = '0;
    step();
  endtask

  task automatic test_drop_valid();
    req_valid[0] = 1'b1; req_addr[7:0] = 8'h40; req_din[7:0] = 8'h77;
    step();
    req_valid[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (m_valid !== 1'b1 || m_addr !== 8'h40 || m_din !== 8'h77) begin
        bad++; $display("FAIL drop_hold cyc=%0d got v=%b a=%h d=%h exp v=1 a=40 d=77", c, m_valid, m_addr, m_din);
      end
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL drop_ready got=%b exp=0001", req_ready); end
    step();
  endtask

  task automatic test_ignore_mready();
    m_ready = 1'b1;
    step(); step();
    m_ready = 1'b0;
    total++; if (req_ready !== 4'b0000 || m_valid !== 1'b0) begin
      bad++; $display("FAIL idle_mready got rdy=%b v=%b exp rdy=0000 v=0", req_ready, m_valid);
    end
  endtask

  task automatic test_contention();
    int gap;
    bit seen;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) req_addr[8*i +: 8] = 8'h50 + 8'(i);
    req_valid = 4'hF;
    gap = 0;
    for (int k = 0; k < 5; k++) begin
      seen = 1'b0;
      for (int w = 0; w < 10 && !seen; w++) begin
        step();
        if (m_valid) seen = 1'b1; else gap++;
      end
      total++; if (!seen) begin bad++; $display("FAIL cont_wait txn=%0d m_valid never rose", k); end
      total++; if (grant_id !== 3'(k % N) || m_addr !== 8'h50 + 8'(k % N)) begin
        bad++; $display("FAIL cont_order txn=%0d got id=%0d a=%h exp id=%0d a=%h", k, grant_id, m_addr, k % N, 8'h50 + 8'(k % N));
      end
      if (k > 0) begin
        total++; if (gap < 2) begin bad++; $display("FAIL cont_gap txn=%0d got=%0d exp>=2", k, gap); end
      end
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      total++; if (req_ready !== 4'(1 << (k % N))) begin
        bad++; $display("FAIL cont_ready txn=%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % N)));
      end
      gap = 1;
    end
    req_valid = '0;
    step();
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL cont_onehot got=%b exp=0000", req_ready); end
  endtask

  task automatic test_reset_busy();
    req_valid = 4'b1000; req_addr[31:24] = 8'h33; req_addr[7:0] = 8'h44;
    step();
    total++; if (m_valid !== 1'b1 || grant_id !== 3'd3) begin
      bad++; $display("FAIL rb_grant got v=%b id=%0d exp v=1 id=3", m_valid, grant_id);
    end
    rst = 1'b1;
    step();
    total++; if (m_valid !== 1'b0 || req_ready !== 4'b0000 || grant_id !== 3'd0) begin
      bad++; $display("FAIL rb_drop got v=%b rdy=%b id=%0d exp v=0 rdy=0000 id=0", m_valid, req_ready, grant_id);
    end
    rst = 1'b0; req_valid = 4'b1001;
    step();
    total++; if (req_ready !== 4'b0000 || grant_id !== 3'd0 || m_addr !== 8'h44) begin
      bad++; $display("FAIL rb_tie got rdy=%b id=%0d a=%h exp rdy=0000 id=0 a=44", req_ready, grant_id, m_addr);
    end
    req_valid = 4'b1000;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    req_valid = '0;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rb_ready got=%b exp=0001", req_ready); end
    step();
  endtask

  task automatic test_timeout();
    req_valid = 4'b0100; req_addr[23:16] = 8'h61;
    step();
`ifdef I2C_ARB_TIMEOUT_EN
    for (int c = 1; c < 16; c++) step();
    total++; if (m_valid !== 1'b1 || req_ready !== 4'b0000) begin
      bad++; $display("FAIL to_hold got v=%b rdy=%b exp v=1 rdy=0000", m_valid, req_ready);
    end
    step();
    total++; if (req_ready !== 4'b0100 || req_err !== 1'b1 || req_dout !== 8'hFF || m_valid !== 1'b0) begin
      bad++; $display("FAIL to_expire got rdy=%b err=%b dout=%h v=%b exp rdy=0100 err=1 dout=ff v=0", req_ready, req_err, req_dout, m_valid);
    end
    step();
    step();
    for (int c = 1; c < 16; c++) step();
    m_ready = 1'b1; m_dout = 8'h5A;
    step();
    m_ready = 1'b0;
    total++; if (req_ready !== 4'b0100 || req_err !== 1'b0 || req_dout !== 8'h5A) begin
      bad++; $display("FAIL to_race got rdy=%b err=%b dout=%h exp rdy=0100 err=0 dout=5a", req_ready, req_err, req_dout);
    end
`else
    for (int c = 0; c < 40; c++) begin
      step();
      if (c == 39) begin
        total++; if (m_valid !== 1'b1 || req_ready !== 4'b0000 || req_err !== 1'b0) begin
          bad++; $display("FAIL nowd_wait got v=%b rdy=%b err=%b exp v=1 rdy=0000 err=0", m_valid, req_ready, req_err);
        end
      end
    end
    m_ready = 1'b1; m_dout = 8'h5A;
    step();
    m_ready = 1'b0;
    total++; if (req_ready !== 4'b0100 || req_err !== 1'b0 || req_dout !== 8'h5A) begin
      bad++; $display("FAIL nowd_done got rdy=%b err=%b dout=%h exp rdy=0100 err=0 dout=5a", req_ready, req_err, req_dout);
    end
`endif
    req_valid = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_return();
    test_drop_valid();
    test_ignore_mready();
    test_contention();
    test_reset_busy();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
